// File: rtl/hex_display_bank_if.sv
// hex_display_bank_if
//   Bus between a debug-value source and the seven-segment display bank.
//   master : drives value/load/enable/blink_mask, observes display/blink_phase.
//   slave  : the display bank itself.
//   value       - binary value to display (DATA_WIDTH bits)
//   load        - capture strobe
//   enable      - 1 shows digits, 0 blanks all segments
//   blink_mask  - per-digit blink enable (NUM_DIGITS bits)
//   display     - active-low segments, digit i at [7i+6:7i], bit0=a .. bit6=g
//   blink_phase - current blink phase (1 = blinking digits dark)
interface hex_display_bank_if #(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0]   value;
   logic                    load;
   logic                    enable;
   logic [NUM_DIGITS-1:0]   blink_mask;
   logic [7*NUM_DIGITS-1:0] display;
   logic                    blink_phase;

   modport master (
      output value, load, enable, blink_mask,
      input  display, blink_phase
   );

   modport slave (
      input  value, load, enable, blink_mask,
      output display, blink_phase
   );
endinterface

// File: rtl/hex_display_bank.sv
// hex_display_bank
//   Registered multi-digit hexadecimal driver for a bank of seven-segment
//   displays. A value is latched on a load strobe, every nibble is decoded to
//   active-low segments, and digits can blink from an internal divider or be
//   blanked globally. All outputs are registered.
// Ports:
//   i_clock - system clock
//   i_reset - synchronous, active-high reset
//   bus     - hex_display_bank_if.slave (value, load, enable, blink_mask in;
//             display, blink_phase out)
// Optional build macro:
//   LEADING_ZERO_BLANK_EN - when defined, digits above digit 0 whose nibble and
//   all higher nibbles are zero are forced off.
module hex_display_bank #(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BLINK_DIV  = 25000000
) (
   input logic               i_clock,
   input logic               i_reset,
   hex_display_bank_if.slave bus
);

   localparam int unsigned HeldW = 4 * NUM_DIGITS;
   localparam int unsigned CntW  = $clog2(BLINK_DIV);

   logic [HeldW-1:0]        w_value_ext;
   logic [HeldW-1:0]        r_held;
   logic [CntW-1:0]         r_cnt;
   logic                    r_phase;
   logic [7*NUM_DIGITS-1:0] r_display;
   logic [7*NUM_DIGITS-1:0] w_display;
   logic                    w_wrap;
   logic [3:0]              w_nib;
   logic [6:0]              w_seg;
`ifdef LEADING_ZERO_BLANK_EN
   logic                    w_upper_zero;
`endif

   // Zero-extend or truncate the input to exactly one nibble per digit.
   for (genvar gi = 0; gi < HeldW; gi++) begin : g_ext
      if (gi < DATA_WIDTH) begin : g_bit
         assign w_value_ext[gi] = bus.value[gi];
      end else begin : g_zero
         assign w_value_ext[gi] = 1'b0;
      end
   end

   function automatic logic [6:0] f_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         4'hF:    seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   assign w_wrap = (r_cnt == CntW'(BLINK_DIV - 1));

   // Next display word from the currently held value and phase, so a load and
   // a wrap on the same edge both show up together on the following edge.
   always_comb begin
      w_display = '1;
      w_nib     = 4'h0;
      w_seg     = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
      w_upper_zero = 1'b1;
`endif
      // Walk from the top digit down so leading-zero state accumulates.
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_nib = r_held[4*i +: 4];
         w_seg = f_decode(w_nib);
`ifdef LEADING_ZERO_BLANK_EN
         w_upper_zero = w_upper_zero & (w_nib == 4'h0);
         if (i > 0 && w_upper_zero) w_seg = 7'h7F;
`endif
         if (!bus.enable || (bus.blink_mask[i] && r_phase)) w_seg = 7'h7F;
         w_display[7*i +: 7] = w_seg;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_held    <= '0;
         r_cnt     <= '0;
         r_phase   <= 1'b0;
         r_display <= '1;
      end else begin
         if (bus.load) r_held <= w_value_ext;
         r_cnt <= w_wrap ? '0 : r_cnt + CntW'(1);
         if (w_wrap) r_phase <= ~r_phase;
         r_display <= w_display;
      end
   end

   assign bus.display     = r_display;
   assign bus.blink_phase = r_phase;

endmodule

// File: tb/tb_hex_display_bank.sv
// Self-checking bench for hex_display_bank: an 8-digit/32-bit instance and a
// 4-digit/20-bit instance, both with BLINK_DIV=4, checked every cycle against
// a behavioural model of held value, blink phase and expected segments.
module tb_hex_display_bank;

   localparam int unsigned Div = 4;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   hex_display_bank_if #(.NUM_DIGITS(8), .DATA_WIDTH(32)) bus ();
   hex_display_bank_if #(.NUM_DIGITS(4), .DATA_WIDTH(20)) bus2 ();

   hex_display_bank #(.NUM_DIGITS(8), .DATA_WIDTH(32), .BLINK_DIV(Div)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus.slave)
   );

   hex_display_bank #(.NUM_DIGITS(4), .DATA_WIDTH(20), .BLINK_DIV(Div)) dut2 (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus2.slave)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Model state
   logic [31:0] m_held;
   logic [31:0] m_held2;
   int unsigned m_k;        // edges since the last reset edge
   bit          m_valid = 0;
   logic [55:0] exp1;
   logic [27:0] exp2;

   function automatic bit f_phase(input int unsigned k);
      return ((k / Div) % 2) != 0;
   endfunction

   function automatic logic [55:0] f_expect(input logic [31:0] held, input int nd,
                                            input bit ph, input bit en,
                                            input logic [7:0] mask);
      logic [55:0] r;
      logic [6:0]  seg;
      logic [3:0]  nib;
      r = '1;
      for (int i = 0; i < nd; i++) begin
         nib = 4'((held >> (4 * i)) & 32'hF);
         seg = SEG_TAB[nib];
`ifdef LEADING_ZERO_BLANK_EN
         if (i > 0 && (held >> (4 * i)) == 32'h0) seg = 7'h7F;
`endif
         if (!en || (mask[i] && ph)) seg = 7'h7F;
         r[7*i +: 7] = seg;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      logic [55:0] tmp;
      @(posedge clk);
      if (rst) begin
         m_held  = 32'h0;
         m_held2 = 32'h0;
         m_k     = 0;
         exp1    = '1;
         exp2    = '1;
         m_valid = 1;
      end else begin
         exp1 = f_expect(m_held, 8, f_phase(m_k), bus.enable, bus.blink_mask);
         tmp  = f_expect(m_held2, 4, f_phase(m_k), bus2.enable, {4'h0, bus2.blink_mask});
         exp2 = tmp[27:0];
         if (bus.load) m_held = bus.value;
         if (bus2.load) m_held2 = {16'h0, bus2.value[15:0]};
         m_k++;
      end
      #1;
      if (m_valid) begin
         chk("display8", {8'h0, bus.display}, {8'h0, exp1});
         chk("phase", {63'h0, bus.blink_phase}, {63'h0, f_phase(m_k)});
         chk("display4", {36'h0, bus2.display}, {36'h0, exp2});
      end
   endtask

   logic [55:0] c_exp;

   initial begin
      bus.value       = 32'h0;
      bus.load        = 1'b0;
      bus.enable      = 1'b1;
      bus.blink_mask  = 8'h00;
      bus2.value      = 20'h0;
      bus2.load       = 1'b0;
      bus2.enable     = 1'b1;
      bus2.blink_mask = 4'h0;

      // 1. reset
      rst = 1'b1;
      tick();
      tick();
      chk("reset_display", {8'h0, bus.display}, {8'h0, 56'hFF_FFFF_FFFF_FFFF});
      chk("reset_phase", {63'h0, bus.blink_phase}, 64'h0);
      rst = 1'b0;

      // 2. load and decode
      bus.value = 32'h0123_ABCD;
      bus.load  = 1'b1;
      tick();
      bus.load  = 1'b0;
      bus.value = $urandom;
      tick();
      chk("digit0_d", {57'h0, bus.display[6:0]}, {57'h0, 7'b0100001});
      chk("digit3_A", {57'h0, bus.display[27:21]}, {57'h0, 7'b0001000});
`ifdef LEADING_ZERO_BLANK_EN
      chk("digit7_blank", {57'h0, bus.display[55:49]}, {57'h0, 7'b1111111});
`else
      chk("digit7_0", {57'h0, bus.display[55:49]}, {57'h0, 7'b1000000});
`endif
      tick();

      // 3. blink digit 0
      bus.blink_mask = 8'h01;
      for (int i = 0; i < 16; i++) tick();
      bus.blink_mask = 8'h00;

      // 4. global blank
      bus.enable = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("blank_all", {8'h0, bus.display}, {8'h0, 56'hFF_FFFF_FFFF_FFFF});
      end
      bus.enable = 1'b1;
      tick();
      tick();

      // 5a. load on the wrap edge
      bus.blink_mask = 8'hFF;
      for (int i = 0; i < Div && (m_k % Div) != Div - 1; i++) tick();
      bus.value = 32'h89AB_CDEF;
      bus.load  = 1'b1;
      tick();
      bus.load  = 1'b0;
      tick();
      bus.blink_mask = 8'h00;
      tick();

      // 5b. reset wins over load
      rst       = 1'b1;
      bus.value = 32'hDEAD_BEEF;
      bus.load  = 1'b1;
      tick();
      chk("rst_load_dark", {8'h0, bus.display}, {8'h0, 56'hFF_FFFF_FFFF_FFFF});
      rst      = 1'b0;
      bus.load = 1'b0;
      tick();
`ifdef LEADING_ZERO_BLANK_EN
      c_exp = {{7{7'h7F}}, 7'b1000000};
`else
      c_exp = {8{7'b1000000}};
`endif
      chk("rst_load_zero", {8'h0, bus.display}, {8'h0, c_exp});

      // 6. width rule on the 4-digit instance
      bus2.value = 20'hF1234;
      bus2.load  = 1'b1;
      tick();
      bus2.load  = 1'b0;
      tick();
      chk("width_1234", {36'h0, bus2.display},
          {36'h0, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

      // 6b. leading-zero case
      bus.value = 32'h0000_00A0;
      bus.load  = 1'b1;
      tick();
      bus.load  = 1'b0;
      tick();
`ifdef LEADING_ZERO_BLANK_EN
      c_exp = {{6{7'h7F}}, 7'b0001000, 7'b1000000};
`else
      c_exp = {{6{7'b1000000}}, 7'b0001000, 7'b1000000};
`endif
      chk("lead_zero_A0", {8'h0, bus.display}, {8'h0, c_exp});

      // Randomised traffic
      for (int i = 0; i < 300; i++) begin
         rst            = ($urandom_range(0, 39) == 0);
         bus.value      = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_0FFF) : $urandom;
         bus.load       = $urandom_range(0, 2) == 0;
         bus.enable     = $urandom_range(0, 5) != 0;
         bus.blink_mask = 8'($urandom);
         bus2.value     = 20'($urandom);
         bus2.load      = $urandom_range(0, 2) == 0;
         bus2.blink_mask = 4'($urandom);
         bus2.enable    = $urandom_range(0, 5) != 0;
         tick();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
